// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and widths for the PLL lock/reset controller
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        EN0,
        EN2,
        RELEASE,
        RUN
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, synchronous active-high reset to 0
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_rst_ctrl.sv
// rtl/pll_lock_rst_ctrl.sv - PLL lock qualification, clock gate sequencing and SoC reset release
// Optional lock-loss counter output under `PLL_LOCK_LOSS_CNT_EN.
module pll_lock_rst_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 100000,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int GATE_SETTLE_CYCLES = 8,
    parameter int RST_HOLD_CYCLES    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               enclk0,
    output logic               enclk2,
    output logic               soc_rst,
    output logic               clk_ready,
`ifdef PLL_LOCK_LOSS_CNT_EN
    output logic [LOSS_W-1:0]  lock_loss_cnt,
`endif
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_MAX = max2(max2(max2(LOCK_TIMEOUT, LOCK_STABLE_CYCLES), RST_HOLD_CYCLES),
                                  max2(PLL_RST_CYCLES, GATE_SETTLE_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [RETRY_W-1:0]   retry_n;
    logic                 lock_s;
    logic                 lost;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_cnt;
        lost    = 1'b0;
        case (state)
            PLL_RST: begin
                cnt_n = cnt + 1'b1;
                if (cnt == RST_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_n = cnt + 1'b1;
                if (lock_s) begin
                    state_n = STABLE;
                end else if (cnt == TO_LAST) begin
                    state_n = PLL_RST;
                    if (retry_cnt != '1) retry_n = retry_cnt + 1'b1;
                end
            end
            STABLE: begin
                // Any low sample restarts qualification from scratch via WAIT_LOCK.
                if (!lock_s)               state_n = WAIT_LOCK;
                else if (cnt == STB_LAST)  state_n = EN0;
                else                       cnt_n   = cnt + 1'b1;
            end
            EN0: begin
                if (!lock_s) begin
                    state_n = PLL_RST;
                    lost    = 1'b1;
                end else if (cnt == GATE_LAST) begin
                    state_n = EN2;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EN2: begin
                if (!lock_s) begin
                    state_n = PLL_RST;
                    lost    = 1'b1;
                end else if (cnt == GATE_LAST) begin
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_n = PLL_RST;
                    lost    = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n = PLL_RST;
                    lost    = 1'b1;
                end
            end
            default: state_n = PLL_RST;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    // Outputs are registered from the next state so gates and reset move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            enclk0    <= 1'b0;
            enclk2    <= 1'b0;
            soc_rst   <= 1'b1;
            clk_ready <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pll_reset <= (state_n == PLL_RST);
            enclk0    <= (state_n == EN0) || (state_n == EN2) || (state_n == RELEASE) || (state_n == RUN);
            enclk2    <= (state_n == EN2) || (state_n == RELEASE) || (state_n == RUN);
            soc_rst   <= (state_n != RUN);
            clk_ready <= (state_n == RUN);
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                               lock_loss_cnt <= '0;
        else if (lost && lock_loss_cnt != '1)  lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
`else
    logic unused_lost;
    assign unused_lost = lost;
`endif

endmodule
